// File: rtl/dmem_req_sequencer.sv
// Serialises the two-pipe MEM bundle onto the single data-memory bus port, pipe 0 first.
// Optional build macro DMEM_SEQ_PERF_CNT_EN adds stall-cycle and bus-request counters.
module dmem_req_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic                req0_write,
    input  logic                req0_uncached,
    input  logic [ADDR_W-1:0]   req0_paddr,
    input  logic [DATA_W-1:0]   req0_wrdata,
    input  logic [DATA_W/8-1:0] req0_byteenable,
    input  logic                req1_valid,
    input  logic                req1_write,
    input  logic                req1_uncached,
    input  logic [ADDR_W-1:0]   req1_paddr,
    input  logic [DATA_W-1:0]   req1_wrdata,
    input  logic [DATA_W/8-1:0] req1_byteenable,
    input  logic                flush,
    output logic                stall,
    output logic                done,
    output logic [DATA_W-1:0]   rsp0_rddata,
    output logic [DATA_W-1:0]   rsp1_rddata,
    output logic                bus_req,
    output logic                bus_write,
    output logic                bus_uncached,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ready,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
`ifdef DMEM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_bus_reqs
`endif
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_after_cpl;

    logic                r_req0_write;
    logic                r_req0_uncached;
    logic [ADDR_W-1:0]   r_req0_paddr;
    logic [DATA_W-1:0]   r_req0_wrdata;
    logic [BE_W-1:0]     r_req0_be;
    logic                r_req1_valid;
    logic                r_req1_write;
    logic                r_req1_uncached;
    logic [ADDR_W-1:0]   r_req1_paddr;
    logic [DATA_W-1:0]   r_req1_wrdata;
    logic [BE_W-1:0]     r_req1_be;
    logic                r_flush;
    logic [DATA_W-1:0]   r_rsp0;
    logic [DATA_W-1:0]   r_rsp1;

    logic                w_latch;
    logic                w_in_issue;
    logic                w_in_wait;
    logic                w_pipe1;
    logic                w_cpl;
    logic                w_drop;
    logic                w_ld0;
    logic                w_ld1;

    assign w_latch    = (r_state == S_IDLE) && !flush && (req0_valid || req1_valid);
    assign w_in_issue = (r_state == S_ISSUE0) || (r_state == S_ISSUE1);
    assign w_in_wait  = (r_state == S_WAIT0)  || (r_state == S_WAIT1);
    assign w_pipe1    = (r_state == S_ISSUE1) || (r_state == S_WAIT1);
    // A completion is either the rvalid in WAIT or a same-cycle ready+rvalid in ISSUE.
    assign w_cpl      = (w_in_issue && bus_ready && bus_rvalid) || (w_in_wait && bus_rvalid);
    assign w_drop     = flush || r_flush;
    assign w_ld0      = w_cpl && !w_drop && !w_pipe1 && !r_req0_write;
    assign w_ld1      = w_cpl && !w_drop &&  w_pipe1 && !r_req1_write;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        if (w_drop)                      w_after_cpl = S_IDLE;
        else if (!w_pipe1 && r_req1_valid) w_after_cpl = S_ISSUE1;
        else                             w_after_cpl = S_DONE;

        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_latch) w_state_nxt = req0_valid ? S_ISSUE0 : S_ISSUE1;
            end
            S_ISSUE0, S_ISSUE1: begin
                if (bus_ready) begin
                    if (bus_rvalid)                w_state_nxt = w_after_cpl;
                    else if (r_state == S_ISSUE0)  w_state_nxt = S_WAIT0;
                    else                           w_state_nxt = S_WAIT1;
                end else if (flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT0, S_WAIT1: begin
                if (bus_rvalid) w_state_nxt = w_after_cpl;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        bus_req      = 1'b0;
        bus_write    = 1'b0;
        bus_uncached = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        bus_be       = '0;
        case (r_state)
            S_IDLE: stall = (req0_valid || req1_valid) && !flush;
            S_ISSUE0: begin
                stall        = 1'b1;
                bus_req      = 1'b1;
                bus_write    = r_req0_write;
                bus_uncached = r_req0_uncached;
                bus_addr     = r_req0_paddr;
                bus_wdata    = r_req0_wrdata;
                bus_be       = r_req0_be;
            end
            S_ISSUE1: begin
                stall        = 1'b1;
                bus_req      = 1'b1;
                bus_write    = r_req1_write;
                bus_uncached = r_req1_uncached;
                bus_addr     = r_req1_paddr;
                bus_wdata    = r_req1_wrdata;
                bus_be       = r_req1_be;
            end
            S_WAIT0, S_WAIT1: stall = 1'b1;
            default: ;
        endcase
    end

    assign done        = (r_state == S_DONE);
    assign rsp0_rddata = r_rsp0;
    assign rsp1_rddata = r_rsp1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req0_write    <= 1'b0;
            r_req0_uncached <= 1'b0;
            r_req0_paddr    <= '0;
            r_req0_wrdata   <= '0;
            r_req0_be       <= '0;
            r_req1_valid    <= 1'b0;
            r_req1_write    <= 1'b0;
            r_req1_uncached <= 1'b0;
            r_req1_paddr    <= '0;
            r_req1_wrdata   <= '0;
            r_req1_be       <= '0;
            r_flush         <= 1'b0;
            r_rsp0          <= '0;
            r_rsp1          <= '0;
        end else begin
            if (w_latch) begin
                r_req0_write    <= req0_write;
                r_req0_uncached <= req0_uncached;
                r_req0_paddr    <= req0_paddr;
                r_req0_wrdata   <= req0_wrdata;
                r_req0_be       <= req0_byteenable;
                r_req1_valid    <= req1_valid;
                r_req1_write    <= req1_write;
                r_req1_uncached <= req1_uncached;
                r_req1_paddr    <= req1_paddr;
                r_req1_wrdata   <= req1_wrdata;
                r_req1_be       <= req1_byteenable;
            end
            if (w_ld0) r_rsp0 <= bus_rdata;
            if (w_ld1) r_rsp1 <= bus_rdata;
            // Remember a flush only while a response is still owed.
            r_flush <= ((w_state_nxt == S_WAIT0) || (w_state_nxt == S_WAIT1)) && w_drop;
        end
    end

`ifdef DMEM_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_breq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_breq  <= '0;
        end else begin
            if (stall)               r_perf_stall <= r_perf_stall + 32'd1;
            if (bus_req && bus_ready) r_perf_breq <= r_perf_breq + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_bus_reqs     = r_perf_breq;
`endif

endmodule

// File: tb/tb_dmem_req_sequencer.sv
// Scoreboard bench for dmem_req_sequencer: expected bus requests and bundle responses
// are queued when stimulus is driven and compared when the DUT issues or completes.
module tb_dmem_req_sequencer;
    typedef struct packed {
        logic        v;
        logic        w;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_write, req0_uncached;
    logic [31:0] req0_paddr, req0_wrdata;
    logic [3:0]  req0_byteenable;
    logic        req1_valid, req1_write, req1_uncached;
    logic [31:0] req1_paddr, req1_wrdata;
    logic [3:0]  req1_byteenable;
    logic        flush;
    logic        stall, done;
    logic [31:0] rsp0_rddata, rsp1_rddata;
    logic        bus_req, bus_write, bus_uncached;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;
`ifdef DMEM_SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_bus_reqs;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          rdy_dly = 0;
    int          rv_dly  = 2;
    int          n_grant = 0;
    req_t        exp_bus[$];
    logic [63:0] exp_rsp[$];
    logic [31:0] m_rsp0 = '0;
    logic [31:0] m_rsp1 = '0;

    dmem_req_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_uncached(req0_uncached),
        .req0_paddr(req0_paddr), .req0_wrdata(req0_wrdata), .req0_byteenable(req0_byteenable),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_uncached(req1_uncached),
        .req1_paddr(req1_paddr), .req1_wrdata(req1_wrdata), .req1_byteenable(req1_byteenable),
        .flush(flush), .stall(stall), .done(done),
        .rsp0_rddata(rsp0_rddata), .rsp1_rddata(rsp1_rddata),
        .bus_req(bus_req), .bus_write(bus_write), .bus_uncached(bus_uncached),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
`ifdef DMEM_SEQ_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_bus_reqs(perf_bus_reqs)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    function automatic req_t mk(input logic v, input logic w, input logic u,
                                input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_t r;
        r.v = v; r.w = w; r.u = u; r.a = a; r.d = d; r.be = be;
        return r;
    endfunction

    task automatic drive(input req_t r0, input req_t r1);
        req0_valid = r0.v; req0_write = r0.w; req0_uncached = r0.u;
        req0_paddr = r0.a; req0_wrdata = r0.d; req0_byteenable = r0.be;
        req1_valid = r1.v; req1_write = r1.w; req1_uncached = r1.u;
        req1_paddr = r1.a; req1_wrdata = r1.d; req1_byteenable = r1.be;
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Bus slave: grants after rdy_dly waiting cycles, completes rv_dly cycles after the grant.
    initial begin : responder
        int          wait_cnt;
        int          rv_cnt;
        logic        pend;
        logic        was_pend;
        logic [31:0] pend_data;
        logic [31:0] data;
        req_t        snap;
        req_t        e;
        wait_cnt = 0; rv_cnt = 0; pend = 1'b0; pend_data = '0; snap = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            was_pend   = pend;
            if (pend) begin
                if (rv_cnt <= 1) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = pend_data;
                    pend       = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (bus_req) begin
                if (was_pend) begin
                    chk("bus_overlap", {31'd0, bus_req}, 32'd0);
                end else begin
                    if (wait_cnt == 0) begin
                        snap = mk(1'b1, bus_write, bus_uncached, bus_addr, bus_wdata, bus_be);
                    end else begin
                        chk("hold_addr", bus_addr, snap.a);
                        chk("hold_wdata", bus_wdata, snap.d);
                        chk("hold_be", {28'd0, bus_be}, {28'd0, snap.be});
                        chk("hold_stall", {31'd0, stall}, 32'd1);
                    end
                    if (wait_cnt >= rdy_dly) begin
                        bus_ready = 1'b1;
                        wait_cnt  = 0;
                        n_grant++;
                        if (exp_bus.size() == 0) begin
                            chk("bus_unexpected", bus_addr, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_bus.pop_front();
                            chk("bus_write", {31'd0, bus_write}, {31'd0, e.w});
                            chk("bus_uncached", {31'd0, bus_uncached}, {31'd0, e.u});
                            chk("bus_addr", bus_addr, e.a);
                            chk("bus_wdata", bus_wdata, e.d);
                            chk("bus_be", {28'd0, bus_be}, {28'd0, e.be});
                        end
                        data = bus_write ? 32'hBADC_0DE5 : mem_word(bus_addr);
                        if (rv_dly == 0) begin
                            bus_rvalid = 1'b1;
                            bus_rdata  = data;
                        end else begin
                            pend      = 1'b1;
                            rv_cnt    = rv_dly;
                            pend_data = data;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (done) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_rsp.pop_front();
                chk("rsp0", rsp0_rddata, e[63:32]);
                chk("rsp1", rsp1_rddata, e[31:0]);
            end
        end
    end

    task automatic run_bundle(input req_t r0, input req_t r1);
        bit got;
        if (r0.v) exp_bus.push_back(r0);
        if (r1.v) exp_bus.push_back(r1);
        if (r0.v && !r0.w) m_rsp0 = mem_word(r0.a);
        if (r1.v && !r1.w) m_rsp1 = mem_word(r1.a);
        exp_rsp.push_back({m_rsp0, m_rsp1});
        @(negedge clk);
        drive(r0, r1);
        #1 chk("stall_on_req", {31'd0, stall}, 32'd1);
        @(negedge clk);
        clear_reqs();
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!stall) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("bundle_timeout", {31'd0, stall}, 32'd0);
        else      chk("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("done_once", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!stall) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk(tag, {31'd0, stall}, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        req_t r0, r1, none;
        int   base;
        none = '0;
        rst_n = 1'b0;
        flush = 1'b0;
        drive(none, none);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_rsp0", rsp0_rddata, 32'd0);
        chk("rst_rsp1", rsp1_rddata, 32'd0);
        rst_n = 1'b1;

        // Single load, completion two cycles after the grant.
        rdy_dly = 0; rv_dly = 2;
        run_bundle(mk(1, 0, 0, 32'h0000_1004, 32'h0, 4'hF), none);
        chk("t1_rsp0", rsp0_rddata, 32'hDEAD_BEEF);

        // Store on pipe 0 then load on pipe 1.
        run_bundle(mk(1, 1, 0, 32'h0000_0100, 32'h1122_3344, 4'b0011),
                   mk(1, 0, 0, 32'h0000_0200, 32'h5555_AAAA, 4'hF));
        chk("t2_rsp0_kept", rsp0_rddata, 32'hDEAD_BEEF);

        // Pipe 1 only, uncached.
        run_bundle(none, mk(1, 0, 1, 32'h0000_0300, 32'h0, 4'hF));

        // Long ready back-pressure.
        rdy_dly = 5; rv_dly = 1;
        run_bundle(mk(1, 0, 0, 32'h0000_0400, 32'hCAFE_0001, 4'b1100),
                   mk(1, 1, 1, 32'h0000_0404, 32'h0BAD_F00D, 4'b0001));

        // Ready and rvalid in the same cycle.
        rdy_dly = 0; rv_dly = 0;
        run_bundle(mk(1, 0, 0, 32'h0000_0800, 32'h0, 4'hF),
                   mk(1, 0, 0, 32'h0000_0900, 32'h0, 4'hF));

        // Flush in IDLE: nothing latched.
        @(negedge clk);
        drive(mk(1, 0, 0, 32'h0000_0A00, 32'h0, 4'hF), none);
        flush = 1'b1;
        #1 chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        clear_reqs();
        flush = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_idle_quiet", {31'd0, stall}, 32'd0);

        // Flush in ISSUE0 before the grant.
        rdy_dly = 3; rv_dly = 1;
        @(negedge clk);
        drive(mk(1, 0, 0, 32'h0000_0B00, 32'h0, 4'hF), mk(1, 0, 0, 32'h0000_0B04, 32'h0, 4'hF));
        @(negedge clk);
        clear_reqs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_issue_bus_req", {31'd0, bus_req}, 32'd0);
        chk("flush_issue_stall", {31'd0, stall}, 32'd0);
        repeat (4) @(negedge clk);

        // Flush in WAIT0 with pipe 1 pending.
        rdy_dly = 0; rv_dly = 4;
        exp_bus.push_back(mk(1, 0, 0, 32'h0000_0500, 32'h0, 4'hF));
        @(negedge clk);
        drive(mk(1, 0, 0, 32'h0000_0500, 32'h0, 4'hF), mk(1, 0, 0, 32'h0000_0600, 32'h0, 4'hF));
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_wait_stall", {31'd0, stall}, 32'd1);
        wait_idle("flush_wait_timeout");
        repeat (4) @(negedge clk);
        chk("flush_wait_rsp0", rsp0_rddata, m_rsp0);
        chk("flush_wait_rsp1", rsp1_rddata, m_rsp1);

        // Reset while waiting on pipe 1; the stale completion must be ignored.
        rdy_dly = 0; rv_dly = 4;
        base = n_grant;
        exp_bus.push_back(mk(1, 1, 0, 32'h0000_0700, 32'h7777_0000, 4'hF));
        exp_bus.push_back(mk(1, 0, 0, 32'h0000_0704, 32'h0, 4'hF));
        @(negedge clk);
        drive(mk(1, 1, 0, 32'h0000_0700, 32'h7777_0000, 4'hF), mk(1, 0, 0, 32'h0000_0704, 32'h0, 4'hF));
        @(negedge clk);
        clear_reqs();
        for (int i = 0; i < 100; i++) begin
            if (n_grant >= base + 2) break;
            @(negedge clk);
        end
        chk("rst_wait_grants", n_grant, base + 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("midrst_bus_addr", bus_addr, 32'd0);
        chk("midrst_rsp0", rsp0_rddata, 32'd0);
        chk("midrst_rsp1", rsp1_rddata, 32'd0);
        rst_n = 1'b1;
        m_rsp0 = '0;
        m_rsp1 = '0;
        repeat (6) @(negedge clk);
        chk("stale_rsp1", rsp1_rddata, 32'd0);
        chk("stale_stall", {31'd0, stall}, 32'd0);

        // Mixed random bundles.
        for (int k = 0; k < 10; k++) begin
            logic v0, v1;
            rdy_dly = $urandom_range(0, 2);
            rv_dly  = $urandom_range(0, 3);
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            r0 = mk(v0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {14'd0, 16'($urandom), 2'b00}, $urandom, 4'($urandom_range(1, 15)));
            r1 = mk(v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {14'd0, 16'($urandom), 2'b00}, $urandom, 4'($urandom_range(1, 15)));
            run_bundle(r0, r1);
        end

        repeat (5) @(negedge clk);
        chk("bus_queue_empty", exp_bus.size(), 32'd0);
        chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_req_sequencer.md
Name: dmem_req_sequencer

Overview:
- Sequences the memory requests of both issue pipes onto the single data-memory bus port, in program order.
- Sits between the EX/MEM pipeline registers and the data-cache/uncached bus.
- Stalls the pipeline until every request of the bundle has completed.
- Returns raw 32-bit read words per pipe; the MEM-stage extension/merge logic (LB/LH/LWL/LWR) consumes them unchanged.

Parameters:
- ADDR_W, 32, physical address width.
- DATA_W, 32, data width; byte enable width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req0_valid / req1_valid  in  1  pipe 0 / pipe 1 memory request present
- req0_write / req1_write  in  1  1 = store, 0 = load
- req0_uncached / req1_uncached  in  1  uncached attribute, forwarded to bus
- req0_paddr / req1_paddr  in  ADDR_W  physical address
- req0_wrdata / req1_wrdata  in  DATA_W  store data
- req0_byteenable / req1_byteenable  in  DATA_W/8  byte lanes
- flush  in  1  exception/branch flush of the MEM bundle
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse: bundle complete, rsp data valid
- rsp0_rddata / rsp1_rddata  out  DATA_W  read data for pipe 0 / pipe 1
- bus_req  out  1  request valid
- bus_write  out  1  store request
- bus_uncached  out  1  uncached attribute
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  store data
- bus_be  out  DATA_W/8  byte enables
- bus_ready  in  1  bus accepts the request this cycle
- bus_rvalid  in  1  completion (load data or store ack), exactly one per accepted request
- bus_rdata  in  DATA_W  load data, qualified by bus_rvalid

Behaviour:
- Reset: stall=0, done=0, bus_req=0, all bus_* fields 0, rsp0/rsp1_rddata=0, state IDLE, latched requests cleared. A mid-transaction reset abandons all work; any later bus_rvalid arriving while in IDLE is ignored.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- IDLE:
  - If req0_valid or req1_valid (and flush=0), latch both requests.
  - Go to ISSUE0 if req0_valid, otherwise to ISSUE1.
- ISSUEx:
  - bus_req=1, with bus fields driven from latched request x.
  - Bus fields are held stable until bus_ready.
  - On bus_ready go to WAITx.
  - If bus_rvalid is asserted in the same cycle as bus_ready, treat it as both issue and completion and skip WAITx.
- WAITx:
  - bus_req=0.
  - On bus_rvalid, load rspx_rddata from bus_rdata; for stores, rspx_rddata is unchanged.
  - From WAIT0, go to ISSUE1 if req1 was latched, otherwise to DONE.
  - From WAIT1, go to DONE.
- DONE: done=1, stall=0, go to IDLE. Inputs are ignored in DONE. Every bundle therefore costs at least one extra cycle before the next is accepted.
- stall (combinational) = (IDLE & (req0_valid|req1_valid) & !flush) | state in {ISSUEx, WAITx}.
- Ordering: pipe 0 always completes before pipe 1 is issued. At most one request is outstanding.
- rspx_rddata holds its value until overwritten by a later load on the same pipe.
- flush:
  - In IDLE: the bundle is not latched.
  - In ISSUEx before bus_ready: drop the request, bus_req=0 next cycle, go to IDLE with no done.
  - In ISSUEx on the bus_ready cycle, or in WAITx: drop the remaining pipe-1 request, wait for the outstanding bus_rvalid, discard its data (rsp unchanged), then go to IDLE with no done.
  - While flushing, stall stays 1 until the outstanding response returns.

Optional Feature:
- Macro: DMEM_SEQ_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_bus_reqs[31:0].
  - perf_stall_cycles increments every cycle stall=1.
  - perf_bus_reqs increments on each bus_req&bus_ready.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters do not exist; no other behaviour changes.

Test Plan:
- req0 load at 0x0000_1004, bus_ready on the first cycle, bus_rvalid 2 cycles later with 0xDEADBEEF -> rsp0_rddata=0xDEADBEEF, done pulses once, stall high from the request cycle until DONE.
- req0 store at 0x100 (be 4'b0011) plus req1 load at 0x200 -> bus sees the store first, then the load only after the store's rvalid; rsp1_rddata=bus_rdata; rsp0 unchanged.
- Only req1 valid -> IDLE goes straight to ISSUE1; exactly 1 bus request; done pulses.
- bus_ready held low for 5 cycles -> bus_addr/wdata/be stay stable; stall=1 throughout.
- flush during WAIT0 with req1 pending -> no second bus request; rvalid data discarded; no done; return to IDLE.
- rst_n low during WAIT1 -> next cycle all outputs at reset values; a stale bus_rvalid afterwards has no effect.
